ahb_slave_wr_if: RTL and testbench

AHB-Lite slave front end of the bridge. It sits directly downstream of the AHB master generator and accepts its write transfers: SINGLE and INCR4/8/16 bursts, with BUSY and IDLE cycles between beats. Each accepted beat is lane-masked and byte-strobed, then queued in a request FIFO for the bridge core. Reads and illegal transfers get the two-cycle AHB ERROR response; nothing is queued for them.

---
 rtl/ahb_pkg.sv | 69 ++++++
 rtl/ahb_req_fifo.sv | 61 ++++++
 rtl/ahb_slave_wr_if.sv | 182 ++++++++++++++++++
 tb/tb_ahb_slave_wr_if.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, the request record and the strobe helper used by
// both the slave write front end and the master generator.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3,
    HSIZE_4W    = 3'd4,
    HSIZE_8W    = 3'd5,
    HSIZE_16W   = 3'd6,
    HSIZE_32W   = 3'd7
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Write front-end FSM; state is the register named "state" in the top.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DATA_WR = 2'd1,
    ST_ERR1    = 2'd2,
    ST_ERR2    = 2'd3
  } wr_state_e;

  // Request record at the default bus widths.
  localparam int REQ_ADDR_W = 32;
  localparam int REQ_DATA_W = 64;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0]   addr;
    logic [REQ_DATA_W-1:0]   data;
    logic [REQ_DATA_W/8-1:0] strb;
    logic [2:0]              size;
    logic [2:0]              burst;
    logic                    first;
  } req_t;

  // Widest supported bus is 256 bits, i.e. 32 byte lanes.
  localparam int STRB_MAX = 32;

  // Byte strobes for a transfer of 2^size bytes starting at byte lane 'lane'.
  function automatic logic [STRB_MAX-1:0] gen_strb(input logic [2:0] size,
                                                   input logic [4:0] lane);
    logic [63:0] bytes_mask;
    bytes_mask = (64'd1 << (8'd1 << size)) - 64'd1;
    return STRB_MAX'(bytes_mask << lane);
  endfunction

endpackage

// File: rtl/ahb_req_fifo.sv
// Registered synchronous FIFO of request entries; the head entry drives the
// outputs directly, so a push becomes visible one cycle later.
module ahb_req_fifo
  import ahb_pkg::*;
#(
  parameter type entry_t = req_t,
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage and write pointer; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_wr_if.sv
// AHB-Lite write slave: accepts write beats, lane-masks them and queues them
// for the bridge core; reads and illegal transfers get the two-cycle ERROR.
//
// Request handshake: an entry transfers on a rising HCLK edge where
// req_valid and req_ready are both 1; req_valid never depends on req_ready,
// and req_* stay stable while req_valid=1 and req_ready=0.
module ahb_slave_wr_if
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int AHB_ADDRESS_WIDTH = 32,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HSEL,
  input  logic [AHB_ADDRESS_WIDTH-1:0]  HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  logic [2:0]                    HBURST,
  input  logic [AHB_DATA_WIDTH-1:0]     HWDATA,
  input  logic                          HREADY,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [AHB_ADDRESS_WIDTH-1:0]  req_addr,
  output logic [AHB_DATA_WIDTH-1:0]     req_data,
  output logic [AHB_DATA_WIDTH/8-1:0]   req_strb,
  output logic [2:0]                    req_size,
  output logic [2:0]                    req_burst,
  output logic                          req_first
);

  localparam int STRB_W = AHB_DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [AHB_ADDRESS_WIDTH-1:0] addr;
    logic [AHB_DATA_WIDTH-1:0]    data;
    logic [STRB_W-1:0]            strb;
    logic [2:0]                   size;
    logic [2:0]                   burst;
    logic                         first;
  } wr_req_t;

  logic [1:0]                   rst_pipe;
  logic                         rst;
  wr_state_e                    state;
  wr_state_e                    state_next;
  logic                         accept;
  logic                         illegal;
  logic [7:0]                   align_mask;
  logic                         sample_ok;
  logic                         push;
  logic [AHB_ADDRESS_WIDTH-1:0] ap_addr;
  logic [2:0]                   ap_size;
  logic [2:0]                   ap_burst;
  logic                         ap_first;
  logic [STRB_W-1:0]            beat_strb;
  wr_req_t                      push_entry;
  wr_req_t                      head;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [CNT_W-1:0]             fifo_count;

  // Reset asserts immediately and releases two HCLK edges after HRESET falls.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) rst_pipe <= 2'b11;
    else        rst_pipe <= {rst_pipe[0], 1'b0};
  end
  assign rst = rst_pipe[1];

  assign accept     = HSEL & HREADY & HTRANS[1];
  assign align_mask = (8'd1 << HSIZE) - 8'd1;
  assign illegal    = ~HWRITE | (HSIZE > 3'(LANE_W)) | (|(HADDR[7:0] & align_mask));
  assign sample_ok  = (state == ST_IDLE) | (state == ST_ERR2) |
                      ((state == ST_DATA_WR) & ~fifo_full);

  // State register.
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next state: a new address phase is judged whenever the bus is ready for it.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (accept) state_next = illegal ? ST_ERR1 : ST_DATA_WR;
        else        state_next = ST_IDLE;
      end
      ST_DATA_WR: begin
        if (!fifo_full) begin
          if (accept) state_next = illegal ? ST_ERR1 : ST_DATA_WR;
          else        state_next = ST_IDLE;
        end
      end
      ST_ERR1: state_next = ST_ERR2;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bus response and FIFO push; the data phase stalls only while the FIFO is full.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    push      = 1'b0;
    case (state)
      ST_DATA_WR: begin
        HREADYOUT = ~fifo_full;
        push      = ~fifo_full;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      default: ;
    endcase
  end

  // Address-phase capture for legal beats; illegal ones never reach the FIFO.
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      ap_addr  <= '0;
      ap_size  <= '0;
      ap_burst <= '0;
      ap_first <= 1'b0;
    end else if (accept & ~illegal & sample_ok) begin
      ap_addr  <= HADDR;
      ap_size  <= HSIZE;
      ap_burst <= HBURST;
      ap_first <= (HTRANS == HTRANS_NONSEQ);
    end
  end

  assign beat_strb = STRB_W'(gen_strb(ap_size, 5'(ap_addr[LANE_W-1:0])));

  // Build the queued beat; unused lanes are zeroed because the master drives X there.
  always_comb begin
    push_entry       = '0;
    push_entry.addr  = ap_addr;
    push_entry.strb  = beat_strb;
    push_entry.size  = ap_size;
    push_entry.burst = ap_burst;
    push_entry.first = ap_first;
    for (int i = 0; i < STRB_W; i++)
      push_entry.data[i*8 +: 8] = beat_strb[i] ? HWDATA[i*8 +: 8] : 8'h00;
  end

  ahb_req_fifo #(
    .entry_t (wr_req_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (req_ready),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Occupancy never exceeds capacity and agrees with the empty flag.
  assert property (@(posedge HCLK) disable iff (rst)
    (fifo_count <= CNT_W'(FIFO_DEPTH)) && ((fifo_count == '0) == fifo_empty));

  assign req_valid = ~fifo_empty;
  assign req_addr  = head.addr;
  assign req_data  = head.data;
  assign req_strb  = head.strb;
  assign req_size  = head.size;
  assign req_burst = head.burst;
  assign req_first = head.first;

endmodule

// File: tb/tb_ahb_slave_wr_if.sv
// Directed bench for the AHB-Lite write front end. A single slave on the bus,
// so HREADY is looped back from HREADYOUT. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_ahb_slave_wr_if;
  import ahb_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b1;
  logic          HSEL = 1'b0;
  logic [AW-1:0] HADDR = '0;
  logic [1:0]    HTRANS = T_IDLE;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd0;
  logic [2:0]    HBURST = 3'd0;
  logic [DW-1:0] HWDATA = '0;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic          req_valid;
  logic          req_ready = 1'b1;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [SW-1:0] req_strb;
  logic [2:0]    req_size;
  logic [2:0]    req_burst;
  logic          req_first;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [2:0]    size;
    logic [2:0]    burst;
    logic          first;
  } beat_t;

  beat_t rx_q[$];
  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  ahb_slave_wr_if #(
    .AHB_DATA_WIDTH    (DW),
    .AHB_ADDRESS_WIDTH (AW),
    .FIFO_DEPTH        (4)
  ) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_strb  (req_strb),
    .req_size  (req_size),
    .req_burst (req_burst),
    .req_first (req_first)
  );

  // Record every entry handed to the core (it is popped at the next rising edge).
  always @(negedge HCLK)
    if (!HRESET && req_valid && req_ready)
      rx_q.push_back({req_addr, req_data, req_strb, req_size, req_burst, req_first});

  // ---------------- driver tasks ----------------
  // One AHB cycle: address phase (t,a,sz,b,w) together with data d for the
  // previous beat; returns after the edge that completes it.
  task automatic step(input logic [1:0] t, input logic [AW-1:0] a, input logic [2:0] sz,
                      input logic [2:0] b, input logic w, input logic [DW-1:0] d,
                      output int stalls);
    HSEL = 1'b1; HTRANS = t; HADDR = a; HSIZE = sz; HBURST = b; HWRITE = w; HWDATA = d;
    stalls = 0;
    @(negedge HCLK);
    while (HREADYOUT !== 1'b1 && stalls < 40) begin
      stalls++;
      @(negedge HCLK);
    end
    n_checks++;
    if (stalls >= 40) begin
      n_fail++;
      $display("FAIL step_timeout: HREADYOUT=%b after %0d cycles, required 1", HREADYOUT, stalls);
    end
    @(posedge HCLK); #1;
  endtask

  task automatic idle_cycles(input int n);
    HSEL = 1'b0; HTRANS = T_IDLE; HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL reset_hreadyout: got %b required 1", HREADYOUT); end
    n_checks++; if (HRESP !== 1'b0) begin n_fail++; $display("FAIL reset_hresp: got %b required 0", HRESP); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b required 0", req_valid); end
    n_checks++; if (req_addr !== '0) begin n_fail++; $display("FAIL reset_req_addr: got %h required 0", req_addr); end
    n_checks++; if (req_data !== '0) begin n_fail++; $display("FAIL reset_req_data: got %h required 0", req_data); end
    n_checks++; if (req_strb !== '0) begin n_fail++; $display("FAIL reset_req_strb: got %h required 0", req_strb); end
    n_checks++; if ({req_size, req_burst, req_first} !== 7'd0) begin n_fail++;
      $display("FAIL reset_req_ctrl: got size=%0d burst=%0d first=%b required 0/0/0", req_size, req_burst, req_first); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_incr4();
    int s[5];
    rx_q.delete(); exp_q.delete();
    step(T_NONSEQ, 32'h0, 3'd2, 3'd3, 1'b1, 64'h0, s[0]);
    step(T_SEQ,    32'h4, 3'd2, 3'd3, 1'b1, 64'hDEAD_BEEF_1111_1111, s[1]);
    step(T_SEQ,    32'h8, 3'd2, 3'd3, 1'b1, 64'h2222_2222_CAFE_F00D, s[2]);
    step(T_SEQ,    32'hC, 3'd2, 3'd3, 1'b1, 64'hABCD_0123_3333_3333, s[3]);
    step(T_IDLE,   32'h0, 3'd0, 3'd0, 1'b0, 64'h4444_4444_5A5A_5A5A, s[4]);
    idle_cycles(4);
    exp_q.push_back({32'h0, 64'h0000_0000_1111_1111, 8'h0F, 3'd2, 3'd3, 1'b1});
    exp_q.push_back({32'h4, 64'h2222_2222_0000_0000, 8'hF0, 3'd2, 3'd3, 1'b0});
    exp_q.push_back({32'h8, 64'h0000_0000_3333_3333, 8'h0F, 3'd2, 3'd3, 1'b0});
    exp_q.push_back({32'hC, 64'h4444_4444_0000_0000, 8'hF0, 3'd2, 3'd3, 1'b0});
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (s[i] !== 0) begin n_fail++; $display("FAIL incr4_no_stall%0d: got %0d wait cycles required 0", i, s[i]); end
    end
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL incr4_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL incr4_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_single_byte();
    int s;
    rx_q.delete(); exp_q.delete();
    step(T_NONSEQ, 32'h5, 3'd0, 3'd0, 1'b1, 64'h0, s);
    step(T_IDLE,   32'h0, 3'd0, 3'd0, 1'b0, 64'h1122_AB44_5566_7788, s);
    idle_cycles(4);
    exp_q.push_back({32'h5, 64'h0000_AB00_0000_0000, 8'h20, 3'd0, 3'd0, 1'b1});
    n_checks++;
    if (rx_q.size() !== 1) begin n_fail++; $display("FAIL single_count: got %0d required 1", rx_q.size()); end
    else begin
      n_checks++;
      if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL single_beat: got %h required %h", rx_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_backpressure();
    int s;
    rx_q.delete(); exp_q.delete();
    req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step((k == 0) ? T_NONSEQ : T_SEQ, 32'h20 + 32'(4*k), 3'd2, 3'd5, 1'b1,
           (k == 0) ? 64'h0 : {32'hA000_0000 + 32'(k-1), 32'hB000_0000 + 32'(k-1)}, s);
      n_checks++;
      if (s !== 0) begin n_fail++; $display("FAIL bp_beat%0d_stall: got %0d wait cycles required 0", k, s); end
    end
    // Beat 5 data phase with four entries queued.
    HTRANS = T_SEQ; HADDR = 32'h34; HWDATA = {32'hA000_0004, 32'hB000_0004};
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL bp_full_stall: HREADYOUT=%b required 0", HREADYOUT); end
    @(posedge HCLK); #1;
    req_ready = 1'b1;
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b0) begin n_fail++; $display("FAIL bp_no_bypass: HREADYOUT=%b required 0", HREADYOUT); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL bp_release: HREADYOUT=%b required 1", HREADYOUT); end
    @(posedge HCLK); #1;
    for (int k = 6; k < 8; k++)
      step(T_SEQ, 32'h20 + 32'(4*k), 3'd2, 3'd5, 1'b1,
           {32'hA000_0000 + 32'(k-1), 32'hB000_0000 + 32'(k-1)}, s);
    step(T_IDLE, 32'h0, 3'd0, 3'd0, 1'b0, {32'hA000_0007, 32'hB000_0007}, s);
    idle_cycles(8);
    for (int k = 0; k < 8; k++)
      exp_q.push_back({32'h20 + 32'(4*k),
                       (k % 2 == 0) ? {32'h0, 32'hB000_0000 + 32'(k)} : {32'hA000_0000 + 32'(k), 32'h0},
                       (k % 2 == 0) ? 8'h0F : 8'hF0, 3'd2, 3'd5, (k == 0)});
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_read_error();
    int s;
    rx_q.delete();
    step(T_NONSEQ, 32'h10, 3'd2, 3'd0, 1'b0, 64'h0, s);
    HSEL = 1'b0; HTRANS = T_IDLE;
    @(negedge HCLK);
    n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL rd_err1: HREADYOUT/HRESP=%b%b required 01", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL rd_err2: HREADYOUT/HRESP=%b%b required 11", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    @(negedge HCLK);
    n_checks++; if ({HREADYOUT, HRESP} !== 2'b10) begin n_fail++; $display("FAIL rd_okay: HREADYOUT/HRESP=%b%b required 10", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    idle_cycles(3);
    n_checks++; if (rx_q.size() !== 0) begin n_fail++; $display("FAIL rd_no_push: got %0d entries required 0", rx_q.size()); end
  endtask

  task automatic test_misaligned();
    int s;
    rx_q.delete(); exp_q.delete();
    step(T_NONSEQ, 32'h2, 3'd2, 3'd0, 1'b1, 64'h0, s);
    HSEL = 1'b0; HTRANS = T_IDLE;
    @(negedge HCLK);
    n_checks++; if ({HREADYOUT, HRESP} !== 2'b01) begin n_fail++; $display("FAIL mis_err1: HREADYOUT/HRESP=%b%b required 01", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = T_NONSEQ; HADDR = 32'h8; HSIZE = 3'd2; HBURST = 3'd0; HWRITE = 1'b1;
    @(negedge HCLK);
    n_checks++; if ({HREADYOUT, HRESP} !== 2'b11) begin n_fail++; $display("FAIL mis_err2: HREADYOUT/HRESP=%b%b required 11", HREADYOUT, HRESP); end
    @(posedge HCLK); #1;
    step(T_IDLE, 32'h0, 3'd0, 3'd0, 1'b0, 64'h9999_9999_7777_8888, s);
    idle_cycles(4);
    exp_q.push_back({32'h8, 64'h0000_0000_7777_8888, 8'h0F, 3'd2, 3'd0, 1'b1});
    n_checks++;
    if (rx_q.size() !== 1) begin n_fail++; $display("FAIL mis_follow_count: got %0d required 1", rx_q.size()); end
    else begin
      n_checks++;
      if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL mis_follow_beat: got %h required %h", rx_q[0], exp_q[0]); end
    end
  endtask

  task automatic test_busy();
    int s;
    rx_q.delete(); exp_q.delete();
    step(T_NONSEQ, 32'h40, 3'd2, 3'd3, 1'b1, 64'h0, s);
    step(T_SEQ,    32'h44, 3'd2, 3'd3, 1'b1, 64'h0101_0101_0A0A_0A0A, s);
    step(T_BUSY,   32'h48, 3'd2, 3'd3, 1'b1, 64'h0B0B_0B0B_0202_0202, s);
    step(T_SEQ,    32'h48, 3'd2, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, s);
    step(T_SEQ,    32'h4C, 3'd2, 3'd3, 1'b1, 64'h0C0C_0C0C_0303_0303, s);
    step(T_IDLE,   32'h0,  3'd0, 3'd0, 1'b0, 64'h0404_0404_0D0D_0D0D, s);
    idle_cycles(4);
    exp_q.push_back({32'h40, 64'h0000_0000_0A0A_0A0A, 8'h0F, 3'd2, 3'd3, 1'b1});
    exp_q.push_back({32'h44, 64'h0B0B_0B0B_0000_0000, 8'hF0, 3'd2, 3'd3, 1'b0});
    exp_q.push_back({32'h48, 64'h0000_0000_0303_0303, 8'h0F, 3'd2, 3'd3, 1'b0});
    exp_q.push_back({32'h4C, 64'h0404_0404_0000_0000, 8'hF0, 3'd2, 3'd3, 1'b0});
    n_checks++;
    if (rx_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL busy_count: got %0d required %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL busy_beat%0d: got %h required %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int s;
    rx_q.delete(); exp_q.delete();
    req_ready = 1'b0;
    step(T_NONSEQ, 32'h80, 3'd2, 3'd3, 1'b1, 64'h0, s);
    step(T_SEQ,    32'h84, 3'd2, 3'd3, 1'b1, 64'h1111_1111_2222_2222, s);
    step(T_SEQ,    32'h88, 3'd2, 3'd3, 1'b1, 64'h3333_3333_4444_4444, s);
    HTRANS = T_SEQ; HADDR = 32'h8C; HWDATA = 64'h5555_5555_6666_6666;
    #2;
    n_checks++; if (req_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_valid: got %b required 1", req_valid); end
    HRESET = 1'b1;
    #1;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b required 0", req_valid); end
    n_checks++; if (HREADYOUT !== 1'b1) begin n_fail++; $display("FAIL rst_async_hreadyout: got %b required 1", HREADYOUT); end
    HSEL = 1'b0; HTRANS = T_IDLE;
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 req_ready = 1'b1;
    @(negedge HCLK);
    n_checks++; if ({req_valid, req_addr} !== {1'b0, 32'h0}) begin n_fail++;
      $display("FAIL rst_after_release: req_valid=%b req_addr=%h required 0/0", req_valid, req_addr); end
    @(posedge HCLK); #1;
    step(T_NONSEQ, 32'h90, 3'd1, 3'd0, 1'b1, 64'h0, s);
    step(T_IDLE,   32'h0,  3'd0, 3'd0, 1'b0, 64'h7788_99AA_BBCC_DDEE, s);
    idle_cycles(4);
    exp_q.push_back({32'h90, 64'h0000_0000_0000_DDEE, 8'h03, 3'd1, 3'd0, 1'b1});
    n_checks++;
    if (rx_q.size() !== 1) begin n_fail++; $display("FAIL rst_fresh_count: got %0d required 1", rx_q.size()); end
    else begin
      n_checks++;
      if (rx_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rst_fresh_beat: got %h required %h", rx_q[0], exp_q[0]); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESET = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    test_reset();
    test_incr4();
    test_single_byte();
    test_backpressure();
    test_read_error();
    test_misaligned();
    test_busy();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
